// File: rtl/div_pkg.sv
// Shared constants for the divider: bus widths, FSM state encodings,
// handshake levels and a few two's-complement helpers.
package div_pkg;

  localparam int RegBusWidth       = 32;
  localparam int DoubleRegBusWidth = 64;

  // FSM state encodings
  localparam logic [1:0] DivFree   = 2'b00;
  localparam logic [1:0] DivByZero = 2'b01;
  localparam logic [1:0] DivOn     = 2'b10;
  localparam logic [1:0] DivEnd    = 2'b11;

  // Handshake levels
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  // Two's-complement negation of a register-bus word.
  function automatic logic [RegBusWidth-1:0] neg_word(input logic [RegBusWidth-1:0] v);
    return ~v + 32'd1;
  endfunction

  // Magnitude of a word when the divide is signed and the word is negative.
  function automatic logic [RegBusWidth-1:0] mag_word(input logic is_signed,
                                                      input logic [RegBusWidth-1:0] v);
    return (is_signed && v[RegBusWidth-1]) ? neg_word(v) : v;
  endfunction

  // Apply a conditional negation (sign correction of a result half).
  function automatic logic [RegBusWidth-1:0] fix_sign(input logic do_neg,
                                                      input logic [RegBusWidth-1:0] v);
    return do_neg ? neg_word(v) : v;
  endfunction

endpackage

// File: rtl/div.sv
// 32-bit restoring divider, one quotient bit per cycle.
// result_o = {remainder, quotient}; signed divides round toward zero and
// the remainder takes the sign of the dividend.
// Optional macro DIV_ZERO_DETECT_EN: a zero divisor short-cuts through the
// BYZERO state and returns an all-zero result after two edges instead of
// running the full iteration.
module div
  import div_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         signed_div_i,
  input  logic [RegBusWidth-1:0]       opdata1_i,
  input  logic [RegBusWidth-1:0]       opdata2_i,
  input  logic                         start_i,
  input  logic                         annul_i,
  output logic [DoubleRegBusWidth-1:0] result_o,
  output logic                         ready_o
);

  logic [1:0]             state_r;
  logic [5:0]             cnt_r;
  logic [RegBusWidth-1:0] rem_r;      // partial remainder
  logic [RegBusWidth-1:0] quo_r;      // dividend shifting out, quotient shifting in
  logic [RegBusWidth-1:0] divisor_r;
  logic                   neg_quo_r;
  logic                   neg_rem_r;

  logic [RegBusWidth:0]   partial_s;
  logic                   fits_s;
  logic [RegBusWidth-1:0] rem_next_s;
  logic [RegBusWidth-1:0] quo_next_s;
  logic                   zero_div_s;

`ifdef DIV_ZERO_DETECT_EN
  assign zero_div_s = (opdata2_i == 32'd0);
`else
  assign zero_div_s = 1'b0;
`endif

  // One restoring step: shift in the next dividend bit, trial-subtract, keep or restore.
  always_comb begin
    partial_s  = {rem_r, quo_r[RegBusWidth-1]};
    fits_s     = (partial_s >= {1'b0, divisor_r});
    rem_next_s = partial_s[RegBusWidth-1:0];
    quo_next_s = {quo_r[RegBusWidth-2:0], 1'b0};
    if (fits_s) begin
      // partial < 2*divisor here, so the difference always fits in 32 bits
      rem_next_s = partial_s[RegBusWidth-1:0] - divisor_r;
      quo_next_s = {quo_r[RegBusWidth-2:0], 1'b1};
    end else begin
      rem_next_s = partial_s[RegBusWidth-1:0];
      quo_next_s = {quo_r[RegBusWidth-2:0], 1'b0};
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= DivFree;
      cnt_r     <= 6'd0;
      rem_r     <= 32'd0;
      quo_r     <= 32'd0;
      divisor_r <= 32'd0;
      neg_quo_r <= 1'b0;
      neg_rem_r <= 1'b0;
      ready_o   <= DivResultNotReady;
      result_o  <= 64'd0;
    end else begin
      case (state_r)
        DivFree: begin
          if (start_i == DivStart && !annul_i) begin
            cnt_r     <= 6'd0;
            rem_r     <= 32'd0;
            quo_r     <= mag_word(signed_div_i, opdata1_i);
            divisor_r <= mag_word(signed_div_i, opdata2_i);
            neg_quo_r <= signed_div_i & (opdata1_i[RegBusWidth-1] ^ opdata2_i[RegBusWidth-1]);
            neg_rem_r <= signed_div_i & opdata1_i[RegBusWidth-1];
            state_r   <= zero_div_s ? DivByZero : DivOn;
          end else begin
            state_r <= DivFree;
          end
        end
        DivByZero: begin
          result_o <= 64'd0;
          ready_o  <= DivResultReady;
          state_r  <= DivEnd;
        end
        DivOn: begin
          if (annul_i) begin
            // flushed: drop the operation without touching the outputs
            state_r <= DivFree;
          end else if (cnt_r == 6'd32) begin
            result_o <= {fix_sign(neg_rem_r, rem_r), fix_sign(neg_quo_r, quo_r)};
            ready_o  <= DivResultReady;
            state_r  <= DivEnd;
          end else begin
            rem_r <= rem_next_s;
            quo_r <= quo_next_s;
            cnt_r <= cnt_r + 6'd1;
          end
        end
        DivEnd: begin
          // held until the execute stage drops start; annul is deliberately ignored
          if (start_i == DivStop) begin
            result_o <= 64'd0;
            ready_o  <= DivResultNotReady;
            state_r  <= DivFree;
          end else begin
            state_r <= DivEnd;
          end
        end
        default: begin
          result_o <= 64'd0;
          ready_o  <= DivResultNotReady;
          state_r  <= DivFree;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: expected results and latencies are pushed to a
// scoreboard when a divide is launched and popped when ready_o rises.
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  typedef struct {
    logic [63:0] res;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   err_cnt = 0;
  int   chk_cnt = 0;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference result {rem, quo} computed with 64-bit arithmetic.
  function automatic logic [63:0] model(input logic sg, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [31:0] ma, qq, rr;
    if (b == 32'd0) begin
`ifdef DIV_ZERO_DETECT_EN
      return 64'd0;
`else
      ma = (sg && a[31]) ? (32'd0 - a) : a;
      qq = 32'hFFFF_FFFF;
      rr = ma;
      if (sg && a[31]) begin
        qq = 32'd0 - qq;
        rr = 32'd0 - rr;
      end
      return {rr, qq};
`endif
    end
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q  = sa / sb;
    r  = sa % sb;
    qq = q[31:0];
    rr = r[31:0];
    return {rr, qq};
  endfunction

  function automatic int model_lat(input logic [31:0] b);
`ifdef DIV_ZERO_DETECT_EN
    if (b == 32'd0) return 1;
`endif
    return 33;
  endfunction

  // Launch one divide, wait for ready, check result, hold, release.
  task automatic do_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input logic annul_end);
    exp_t e;
    int   n;
    logic seen;
    e.res = model(sg, a, b);
    e.lat = model_lat(b);
    sb_q.push_back(e);
    @(negedge clk);
    signed_div_i = sg;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(posedge clk);          // edge 0: start sampled
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (ready_o) seen = 1'b1;
      if (n == 3) begin
        // operand changes while busy must be ignored
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~sg;
      end
    end
    e = sb_q.pop_front();
    check_val("latency", 64'(n), 64'(e.lat));
    check_val("result", result_o, e.res);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      annul_i = annul_end;
      @(posedge clk);
      #1;
      check_val("hold_ready", {63'd0, ready_o}, 64'd1);
      check_val("hold_result", result_o, e.res);
    end
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check_val("release_ready", {63'd0, ready_o}, 64'd0);
    check_val("release_result", result_o, 64'd0);
  endtask

  initial begin
    rst          = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    #1;
    check_val("reset_ready", {63'd0, ready_o}, 64'd0);
    check_val("reset_result", result_o, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    do_div(1'b0, 32'd100, 32'd7, 5, 1'b0);
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1, 1'b0);
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 1'b0);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 2, 1'b1);
    do_div(1'b0, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    do_div(1'b0, 32'd5, 32'd0, 0, 1'b0);
    do_div(1'b1, 32'hFFFF_FFF0, 32'd0, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (k[0]) rb = rb >> 20;
      if (rb == 32'd0) rb = 32'd3;
      do_div(k[1], ra, rb, 0, 1'b0);
    end

    // annul after ten iterations, then an immediate new divide
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd9;
    start_i      = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check_val("annul_ready", {63'd0, ready_o}, 64'd0);
    check_val("annul_result", result_o, 64'd0);
    @(negedge clk);
    annul_i = 1'b0;
    do_div(1'b0, 32'd12345, 32'd67, 0, 1'b0);

    // asynchronous reset while the result is being held
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd50;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    repeat (36) @(posedge clk);
    #1;
    check_val("pre_rst_result", result_o, {32'd2, 32'd16});
    #2;
    rst = 1'b0;
    #1;
    check_val("async_rst_ready", {63'd0, ready_o}, 64'd0);
    check_val("async_rst_result", result_o, 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    rst     = 1'b1;

    // reset in the middle of an iteration, then a clean divide
    @(negedge clk);
    opdata1_i = 32'd77;
    opdata2_i = 32'd5;
    start_i   = 1'b1;
    repeat (12) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_val("mid_rst_ready", {63'd0, ready_o}, 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    rst     = 1'b1;
    do_div(1'b1, 32'hFFFF_FF9C, 32'd7, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
